// File: rtl/switch_nport_rr.sv
// switch_nport_rr: N-port packet switch with one FIFO per output, valid/ready
// handshakes on both sides, multicast through a target bitmask and round-robin
// fairness between competing inputs.
//
// Optional feature macro: SWITCH_PKT_CNT_EN
//   defined   -> pkt_cnt port present; one saturating 16-bit delivered-packet
//                counter per output, incremented on each dequeue.
//   undefined -> pkt_cnt port and counters absent.
//
// Grant rules: an input is granted only when every output in its mask has
// space and no earlier-scanned input already claimed one of them. Multicast is
// therefore all-or-nothing, and the enqueue to every target happens on a
// single edge.
module switch_nport_rr #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           in_valid,
    output logic [NUM_PORTS-1:0]           in_ready,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_source,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_target,
    input  logic [NUM_PORTS*DATA_W-1:0]    in_data,
    output logic [NUM_PORTS-1:0]           out_valid,
    input  logic [NUM_PORTS-1:0]           out_ready,
    output logic [NUM_PORTS*NUM_PORTS-1:0] out_source,
    output logic [NUM_PORTS*NUM_PORTS-1:0] out_target,
    output logic [NUM_PORTS*DATA_W-1:0]    out_data
`ifdef SWITCH_PKT_CNT_EN
    ,
    output logic [NUM_PORTS*16-1:0]        pkt_cnt
`endif
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [IDX_W:0]   NP_V    = (IDX_W + 1)'(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_V  = IDX_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(FIFO_DEPTH);

    // Per-input fields unpacked from the flat buses
    logic [NUM_PORTS-1:0] src_a_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0] tgt_a_s  [NUM_PORTS];
    logic [DATA_W-1:0]    data_a_s [NUM_PORTS];

    // Output FIFO storage and control
    logic [NUM_PORTS-1:0] mem_src_r  [NUM_PORTS][FIFO_DEPTH];
    logic [NUM_PORTS-1:0] mem_tgt_r  [NUM_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0]    mem_data_r [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_r   [NUM_PORTS];
    logic [PTR_W-1:0]     wr_ptr_r   [NUM_PORTS];
    logic [CNT_W-1:0]     count_r    [NUM_PORTS];
    logic [IDX_W-1:0]     rr_ptr_r;

    // Arbitration and enqueue steering
    logic [NUM_PORTS-1:0] space_s;
    logic [NUM_PORTS-1:0] deq_s;
    logic [NUM_PORTS-1:0] grant_s;
    logic [NUM_PORTS-1:0] claimed_s;
    logic                 any_grant_s;
    logic [IDX_W-1:0]     first_idx_s;
    logic [IDX_W-1:0]     rr_next_s;
    logic [NUM_PORTS-1:0] enq_s;
    logic [NUM_PORTS-1:0] enq_src_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0] enq_tgt_s  [NUM_PORTS];
    logic [DATA_W-1:0]    enq_data_s [NUM_PORTS];

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_port
            assign src_a_s[g]  = in_source[g*NUM_PORTS +: NUM_PORTS];
            assign tgt_a_s[g]  = in_target[g*NUM_PORTS +: NUM_PORTS];
            assign data_a_s[g] = in_data[g*DATA_W +: DATA_W];

            // Space comes from the registered count only: no full-FIFO pass-through.
            assign space_s[g]   = (count_r[g] < DEPTH_V);
            assign out_valid[g] = (count_r[g] != {CNT_W{1'b0}});
            assign deq_s[g]     = out_valid[g] & out_ready[g];

            assign out_source[g*NUM_PORTS +: NUM_PORTS] = mem_src_r[g][rd_ptr_r[g]];
            assign out_target[g*NUM_PORTS +: NUM_PORTS] = mem_tgt_r[g][rd_ptr_r[g]];
            assign out_data[g*DATA_W +: DATA_W]         = mem_data_r[g][rd_ptr_r[g]];
        end
    endgenerate

    assign in_ready = grant_s;

    // Round-robin scan from rr_ptr; each grant claims all of its target outputs
    always_comb begin
        logic [IDX_W:0]   sum_v;
        logic [IDX_W-1:0] idx_v;
        grant_s     = {NUM_PORTS{1'b0}};
        claimed_s   = {NUM_PORTS{1'b0}};
        any_grant_s = 1'b0;
        first_idx_s = rr_ptr_r;
        sum_v       = {(IDX_W + 1){1'b0}};
        idx_v       = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum_v = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
            idx_v = (sum_v >= NP_V) ? IDX_W'(sum_v - NP_V) : IDX_W'(sum_v);
            if (rst_n && in_valid[idx_v] &&
                ((tgt_a_s[idx_v] & ~space_s) == {NUM_PORTS{1'b0}}) &&
                ((tgt_a_s[idx_v] & claimed_s) == {NUM_PORTS{1'b0}})) begin
                grant_s[idx_v] = 1'b1;
                claimed_s      = claimed_s | tgt_a_s[idx_v];
                if (!any_grant_s) begin
                    first_idx_s = idx_v;
                end else begin
                    first_idx_s = first_idx_s;
                end
                any_grant_s = 1'b1;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Next round-robin start: one past the first granted input, wrapping at NUM_PORTS
    always_comb begin
        rr_next_s = {IDX_W{1'b0}};
        if (first_idx_s == LAST_V) begin
            rr_next_s = {IDX_W{1'b0}};
        end else begin
            rr_next_s = first_idx_s + IDX_W'(1);
        end
    end

    // Steer the single granted packet (if any) onto each output's write port
    always_comb begin
        logic hit_v;
        hit_v = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            enq_s[o]      = 1'b0;
            enq_src_s[o]  = {NUM_PORTS{1'b0}};
            enq_tgt_s[o]  = {NUM_PORTS{1'b0}};
            enq_data_s[o] = {DATA_W{1'b0}};
            for (int i = 0; i < NUM_PORTS; i++) begin
                hit_v         = grant_s[i] & tgt_a_s[i][o];
                enq_s[o]      = enq_s[o] | hit_v;
                enq_src_s[o]  = enq_src_s[o]  | (src_a_s[i]  & {NUM_PORTS{hit_v}});
                enq_tgt_s[o]  = enq_tgt_s[o]  | (tgt_a_s[i]  & {NUM_PORTS{hit_v}});
                enq_data_s[o] = enq_data_s[o] | (data_a_s[i] & {DATA_W{hit_v}});
            end
        end
    end

    // FIFO pointers, occupancy and the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {IDX_W{1'b0}};
            for (int o = 0; o < NUM_PORTS; o++) begin
                rd_ptr_r[o] <= {PTR_W{1'b0}};
                wr_ptr_r[o] <= {PTR_W{1'b0}};
                count_r[o]  <= {CNT_W{1'b0}};
            end
        end else begin
            if (any_grant_s) begin
                rr_ptr_r <= rr_next_s;
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (enq_s[o]) begin
                    wr_ptr_r[o] <= wr_ptr_r[o] + PTR_W'(1);
                end
                if (deq_s[o]) begin
                    rd_ptr_r[o] <= rd_ptr_r[o] + PTR_W'(1);
                end
                case ({enq_s[o], deq_s[o]})
                    2'b10:   count_r[o] <= count_r[o] + CNT_W'(1);
                    2'b01:   count_r[o] <= count_r[o] - CNT_W'(1);
                    default: count_r[o] <= count_r[o];
                endcase
            end
        end
    end

    // FIFO payload storage; contents are meaningless while the FIFO is empty
    always_ff @(posedge clk) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (enq_s[o]) begin
                mem_src_r[o][wr_ptr_r[o]]  <= enq_src_s[o];
                mem_tgt_r[o][wr_ptr_r[o]]  <= enq_tgt_s[o];
                mem_data_r[o][wr_ptr_r[o]] <= enq_data_s[o];
            end
        end
    end

`ifdef SWITCH_PKT_CNT_EN
    logic [15:0] pkt_cnt_r [NUM_PORTS];

    // Saturating delivered-packet counter per output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                pkt_cnt_r[o] <= 16'h0000;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (deq_s[o] && (pkt_cnt_r[o] != 16'hFFFF)) begin
                    pkt_cnt_r[o] <= pkt_cnt_r[o] + 16'h0001;
                end
            end
        end
    end

    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_cnt
            assign pkt_cnt[g*16 +: 16] = pkt_cnt_r[g];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_switch_nport_rr.sv
// Directed testbench for switch_nport_rr (NUM_PORTS=4, DATA_W=8, FIFO_DEPTH=8).
// Inputs change 1 time unit after a rising edge; checks are taken 1 unit later.
module tb_switch_nport_rr;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*N-1:0] in_source;
    logic [N*N-1:0] in_target;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*N-1:0] out_source;
    logic [N*N-1:0] out_target;
    logic [N*W-1:0] out_data;
`ifdef SWITCH_PKT_CNT_EN
    logic [N*16-1:0] pkt_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    switch_nport_rr #(.NUM_PORTS(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_source  (in_source),
        .in_target  (in_target),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_source (out_source),
        .out_target (out_target),
        .out_data   (out_data)
`ifdef SWITCH_PKT_CNT_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [N-1:0] src, input logic [N-1:0] tgt,
                         input logic [W-1:0] d);
        in_source[i*N +: N] = src;
        in_target[i*N +: N] = tgt;
        in_data[i*W +: W]   = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '1;
        in_source = '0;
        in_target = '0;
        in_data   = '0;

        // Reset state
        #12;
        chk("reset_out_valid", out_valid, 4'b0000);
        chk("reset_in_ready", in_ready, 4'b0000);
        drive(0, 4'h1, 4'b0100, 8'hEE);
        in_valid = 4'b0001;
        #1;
        chk("reset_in_ready_gated", in_ready, 4'b0000);
        in_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();

        // Unicast in0 -> out2 (rr starts at 0, ends at 1)
        drive(0, 4'h1, 4'b0100, 8'hA5);
        in_valid = 4'b0001;
        #1;
        chk("uc_in_ready", in_ready, 4'b0001);
        tick();
        in_valid = 4'b0000;
        #1;
        chk("uc_out_valid", out_valid, 4'b0100);
        chk("uc_out_data", out_data[2*W +: W], 8'hA5);
        chk("uc_out_source", out_source[2*N +: N], 4'h1);
        tick();

        // Multicast in1 -> outs 0,1,3 (rr becomes 2)
        drive(1, 4'h2, 4'b1011, 8'h3C);
        in_valid = 4'b0010;
        #1;
        chk("mc_in_ready", in_ready, 4'b0010);
        tick();
        in_valid = 4'b0000;
        #1;
        chk("mc_out_valid", out_valid, 4'b1011);
        chk("mc_data0", out_data[0*W +: W], 8'h3C);
        chk("mc_data1", out_data[1*W +: W], 8'h3C);
        chk("mc_data3", out_data[3*W +: W], 8'h3C);
        chk("mc_target3", out_target[3*N +: N], 4'b1011);
        tick();

        // Contention on out0 from all inputs; rr=2 so order is 2,3,0,1,2
        for (int i = 0; i < N; i++) begin
            drive(i, 4'(i + 1), 4'b0001, 8'(8'h10 + i));
        end
        in_valid = 4'b1111;
        #1;
        chk("rr_grant_a", in_ready, 4'b0100);
        tick();
        #1;
        chk("rr_grant_b", in_ready, 4'b1000);
        chk("rr_data_b", out_data[0*W +: W], 8'h12);
        tick();
        #1;
        chk("rr_grant_c", in_ready, 4'b0001);
        chk("rr_data_c", out_data[0*W +: W], 8'h13);
        tick();
        #1;
        chk("rr_grant_d", in_ready, 4'b0010);
        chk("rr_data_d", out_data[0*W +: W], 8'h10);
        tick();
        #1;
        chk("rr_grant_e", in_ready, 4'b0100);
        chk("rr_data_e", out_data[0*W +: W], 8'h11);
        tick();
        in_valid = 4'b0000;
        #1;
        chk("rr_data_f", out_data[0*W +: W], 8'h12);
        chk("rr_out_valid_f", out_valid, 4'b0001);
        tick();
        #1;
        chk("rr_drained", out_valid, 4'b0000);

        // Fill out1 (out_ready[1]=0) with 8 packets from in2, 9th blocked
        out_ready = 4'b1101;
        in_valid  = 4'b0100;
        for (int k = 0; k < D; k++) begin
            drive(2, 4'h3, 4'b0010, 8'(8'h40 + k));
            #1;
            chk("full_accept", in_ready, 4'b0100);
            tick();
        end
        drive(2, 4'h3, 4'b0010, 8'h48);
        #1;
        chk("full_block", in_ready, 4'b0000);
        chk("full_head", out_data[1*W +: W], 8'h40);
        tick();
        out_ready = 4'b1111;
        #1;
        chk("no_passthrough", in_ready, 4'b0000);
        tick();
        out_ready = 4'b1101;
        #1;
        chk("space_after_deq", in_ready, 4'b0100);
        tick();
        in_valid  = 4'b0000;
        out_ready = 4'b1111;
        for (int k = 1; k <= D; k++) begin
            #1;
            chk("fifo_order", out_data[1*W +: W], 8'(8'h40 + k));
            tick();
        end
        #1;
        chk("full_drained", out_valid, 4'b0000);

        // Fill out3, then multicast to {0,3} is refused while unicast to 0 wins
        out_ready = 4'b0111;
        in_valid  = 4'b1000;
        for (int k = 0; k < D; k++) begin
            drive(3, 4'h4, 4'b1000, 8'(8'h60 + k));
            tick();
        end
        in_valid = 4'b0000;
        drive(0, 4'h1, 4'b1001, 8'h77);
        drive(1, 4'h2, 4'b0001, 8'h88);
        in_valid = 4'b0011;
        #1;
        chk("partial_full_mc", in_ready, 4'b0010);
        tick();
        in_valid = 4'b0000;
        #1;
        chk("pf_out_valid", out_valid, 4'b1001);
        chk("pf_out_data0", out_data[0*W +: W], 8'h88);
        tick();
        #1;
        chk("no_partial_write", out_valid, 4'b1000);

        // Queue 5 on out2, dequeue 3, then reset mid-stream
        out_ready = 4'b0011;
        in_valid  = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            drive(2, 4'h3, 4'b0100, 8'(8'hB0 + k));
            tick();
        end
        in_valid = 4'b0000;
        #1;
        chk("queued_out_valid", out_valid, 4'b1100);
        out_ready = 4'b0111;
        tick();
        tick();
        tick();
        out_ready = 4'b0011;
        #1;
        chk("partial_drain_head", out_data[2*W +: W], 8'hB3);
`ifdef SWITCH_PKT_CNT_EN
        chk("pkt_cnt2", pkt_cnt[2*16 +: 16], 16'd4);
        chk("pkt_cnt1", pkt_cnt[1*16 +: 16], 16'd10);
`endif
        rst_n = 1'b0;
        #1;
        chk("reset_midstream", out_valid, 4'b0000);
`ifdef SWITCH_PKT_CNT_EN
        chk("pkt_cnt_reset", pkt_cnt[2*16 +: 16], 16'd0);
`endif
        tick();
        rst_n     = 1'b1;
        out_ready = 4'b1111;
        tick();
        #1;
        chk("post_reset_empty", out_valid, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
